// File: rtl/image_frame_loader_pkg.sv
// rtl/image_frame_loader_pkg.sv - shared image geometry constants and loader types
package image_frame_loader_pkg;

    localparam int IMG_IX      = 28;
    localparam int IMG_IY      = 28;
    localparam int IMG_BW      = 8;
    localparam int FRAME_WORDS = IMG_IX * IMG_IY;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STREAM,
        RD_GAP
    } rd_state_t;

    // Never returns zero so single-entry counters still get a legal vector width.
    function automatic int addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int FRAME_AW = addr_width(FRAME_WORDS);

endpackage

// File: rtl/frame_bank_ram.sv
// rtl/frame_bank_ram.sv - two-bank simple dual-port frame store, registered read
module frame_bank_ram #(
    parameter int WORDS = 784,
    parameter int DW    = 8,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW:0]   rd_addr,
    output logic [DW-1:0] rd_data
);

    // Address MSB selects the bank, the low bits index a pixel inside it.
    logic [DW-1:0] mem [0:1][0:WORDS-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[AW]][wr_addr[AW-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr[AW]][rd_addr[AW-1:0]];
    end

endmodule

// File: rtl/image_frame_loader.sv
// rtl/image_frame_loader.sv - ping-pong frame loader streaming whole frames to the cnn core
module image_frame_loader
    import image_frame_loader_pkg::*;
#(
    parameter int IX      = IMG_IX,
    parameter int IY      = IMG_IY,
    parameter int I_F_BW  = IMG_BW,
    parameter int GAP_CYC = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_valid,
    input  logic [I_F_BW-1:0] i_wr_data,
    input  logic              i_wr_sof,
    output logic              o_wr_ready,
    output logic [I_F_BW-1:0] o_pixel,
    output logic              o_out_valid,
    output logic              o_frame_done,
    output logic              o_drop
);

    localparam int FRAME = IX * IY;
    localparam int AW    = addr_width(FRAME);
    localparam int GW    = addr_width(GAP_CYC);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    logic [1:0]        full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wr_bank;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     wr_slot;
    logic              wr_en;
    logic              wr_last;
    logic              rd_bank;
    logic [AW-1:0]     rd_addr;
    logic              rd_last;
    logic [GW-1:0]     gap_cnt;
    rd_state_t         state;
    logic [I_F_BW-1:0] ram_rd_data;

    // Ready is forced low while reset is held so no write can slip in.
    assign o_wr_ready = reset_n & ~full[wr_bank];
    assign wr_en      = i_wr_valid & o_wr_ready;
    assign wr_slot    = i_wr_sof ? '0 : wr_addr;
    assign wr_last    = wr_en && (wr_slot == LAST_ADDR);
    assign rd_last    = (state == RD_STREAM) && (rd_addr == LAST_ADDR);

    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_last) begin
            full_set[wr_bank] = 1'b1;
        end
        if (rd_last) begin
            full_clr[rd_bank] = 1'b1;
        end
    end

    // Writer only touches a non-full bank and reader only clears a full one,
    // so set and clear never target the same bank and both always land.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr <= '0;
            wr_bank <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            o_drop <= wr_en && i_wr_sof && (wr_addr != '0);
            if (wr_en) begin
                if (wr_last) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_slot + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RD_IDLE;
            rd_addr      <= '0;
            rd_bank      <= 1'b0;
            gap_cnt      <= '0;
            o_out_valid  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_out_valid  <= (state == RD_STREAM);
            o_frame_done <= rd_last;
            case (state)
                RD_IDLE: begin
                    if (full[rd_bank]) begin
                        rd_addr <= '0;
                        state   <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (rd_addr == LAST_ADDR) begin
                        rd_addr <= '0;
                        rd_bank <= ~rd_bank;
                        gap_cnt <= '0;
                        state   <= RD_GAP;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                RD_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= RD_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    frame_bank_ram #(
        .WORDS(FRAME),
        .DW   (I_F_BW),
        .AW   (AW)
    ) u_frame_bank_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr({wr_bank, wr_slot}),
        .wr_data(i_wr_data),
        .rd_addr({rd_bank, rd_addr}),
        .rd_data(ram_rd_data)
    );

    assign o_pixel = o_out_valid ? ram_rd_data : '0;

endmodule
